// File: rtl/tff_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tff_burst_arbiter
// Brief   : Round-robin burst arbiter sharing one T-flip-flop counter among
//           NREQ requesters. Optional abort-on-request-drop: TFF_ARB_ABORT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tff_burst_arbiter #(
  parameter int NREQ  = 4,
  parameter int CW    = 4,
  parameter int LEN_W = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic [2:0]            owner,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [CW-1:0]         cnt,
  output logic                  y
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [2:0]        owner_q, owner_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              pend_q, pend_d;

  logic [CW-1:0]     tff_t;
  logic              found;
  logic [2:0]        sel;
  logic              owner_live;

  // Toggle terms before the enable: bit i flips when every lower bit is one.
  assign tff_t[0] = 1'b1;
  for (genvar i = 1; i < CW; i++) begin : g_tff
    assign tff_t[i] = &cnt_q[i-1:0];
  end

`ifdef TFF_ARB_ABORT_EN
  assign owner_live = |(req & gnt_q);
`else
  assign owner_live = 1'b1;
`endif

  always_comb begin
    found = 1'b0;
    sel   = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        sel   = 3'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    pend_d    = pend_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d   = NREQ'(1) << sel;
          owner_d = sel;
          rem_d   = len[int'(sel)*LEN_W +: LEN_W];
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!owner_live) begin
          pend_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q ^ tff_t;
          if (rem_q == '0) state_d = S_DONE;
          else             rem_d   = rem_q - LEN_W'(1);
        end
      end
      S_DONE: begin
        gnt_d     = '0;
        done_d    = 1'b1;
        aborted_d = pend_q;
        pend_d    = 1'b0;
        ptr_d     = (owner_q == 3'(NREQ - 1)) ? 3'd0 : owner_q + 3'd1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      owner_q   <= 3'd0;
      ptr_q     <= 3'd0;
      rem_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      pend_q    <= pend_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign aborted = aborted_q;
  assign cnt     = cnt_q;
  assign y       = &cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tff_burst_arbiter.sv
`default_nettype none
// Testbench for tff_burst_arbiter: directed scenarios plus randomized bursts
// checked against a transaction-level round-robin model.
module tb_tff_burst_arbiter;
  localparam int NREQ  = 4;
  localparam int CW    = 4;
  localparam int LEN_W = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*LEN_W-1:0] len = '0;
  logic [NREQ-1:0]       gnt;
  logic [2:0]            owner;
  logic                  busy, done, aborted, y;
  logic [CW-1:0]         cnt;

  int errors = 0;
  int checks = 0;
  int m_ptr  = 0;

  tff_burst_arbiter #(.NREQ(NREQ), .CW(CW), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RST(RST), .req(req), .len(len), .gnt(gnt), .owner(owner),
    .busy(busy), .done(done), .aborted(aborted), .cnt(cnt), .y(y)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Round-robin rule: first requester at or above the pointer, wrapping.
  function automatic int winner(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++)
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic set_len(input int i, input int l);
    len[i*LEN_W +: LEN_W] = LEN_W'(l);
  endtask

  // One full burst from the grant edge to the done pulse; DUT must be idle.
  task automatic do_burst(input int w, input int l, input int drop_after,
                          input string tag, input bit scramble, output int fin);
    logic [NREQ-1:0] eg;
    int c;
    bit ab;
    eg = NREQ'(1) << w;
    c  = 0;
    ab = 1'b0;
    tick();
    checks++;
    if (gnt !== eg || owner !== 3'(w) || busy !== 1'b1 || cnt !== '0 ||
        done !== 1'b0 || aborted !== 1'b0) begin
      errors++;
      $display("FAIL %s grant: gnt=%b owner=%0d busy=%b cnt=%0d done=%b aborted=%b, want gnt=%b owner=%0d busy=1 cnt=0 done=0 aborted=0",
               tag, gnt, owner, busy, cnt, done, aborted, eg, w);
    end
    if (scramble) len = (NREQ*LEN_W)'($urandom);
    for (int s = 1; s <= l + 1; s++) begin
      if (s - 1 == drop_after) begin
        req[w] = 1'b0;
`ifdef TFF_ARB_ABORT_EN
        ab = 1'b1;
        break;
`endif
      end
      tick();
      c = (c + 1) % (CMAX + 1);
      checks++;
      if (cnt !== CW'(c) || y !== (c == CMAX) || gnt !== eg || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s step %0d: cnt=%0d y=%b gnt=%b busy=%b done=%b, want cnt=%0d y=%b gnt=%b busy=1 done=0",
                 tag, s, cnt, y, gnt, busy, done, c, (c == CMAX), eg);
      end
    end
    if (ab) begin
      tick();
      checks++;
      if (cnt !== CW'(c) || busy !== 1'b1 || done !== 1'b0 || gnt !== eg) begin
        errors++;
        $display("FAIL %s abort edge: cnt=%0d busy=%b done=%b gnt=%b, want cnt=%0d busy=1 done=0 gnt=%b",
                 tag, cnt, busy, done, gnt, c, eg);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || aborted !== ab || gnt !== '0 || busy !== 1'b0 ||
        cnt !== CW'(c) || owner !== 3'(w)) begin
      errors++;
      $display("FAIL %s done: done=%b aborted=%b gnt=%b busy=%b cnt=%0d owner=%0d, want done=1 aborted=%b gnt=0 busy=0 cnt=%0d owner=%0d",
               tag, done, aborted, gnt, busy, cnt, owner, ab, c, w);
    end
    m_ptr = (w + 1) % NREQ;
    fin   = c;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) tick();
    checks++;
    if (gnt !== '0 || owner !== 3'd0 || busy !== 1'b0 || done !== 1'b0 ||
        aborted !== 1'b0 || cnt !== '0 || y !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: gnt=%b owner=%0d busy=%b done=%b aborted=%b cnt=%0d y=%b, want all 0",
               gnt, owner, busy, done, aborted, cnt, y);
    end
    RST = 1'b0;
    req = 4'b0100;
    set_len(2, 7);
    repeat (3) tick();
    RST = 1'b1;
    req = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (gnt !== '0 || owner !== 3'd0 || busy !== 1'b0 || done !== 1'b0 ||
          aborted !== 1'b0 || cnt !== '0 || y !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid %0d: gnt=%b owner=%0d busy=%b done=%b aborted=%b cnt=%0d, want all 0",
                 i, gnt, owner, busy, done, aborted, cnt);
      end
    end
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || gnt !== '0 || cnt !== '0) begin
        errors++;
        $display("FAIL reset_after %0d: done=%b busy=%b gnt=%b cnt=%0d, want 0 0 0 0",
                 i, done, busy, gnt, cnt);
      end
    end
    m_ptr = 0;
  endtask

  task automatic test_round_robin();
    int fin;
    req = '1;
    len = '0;
    for (int i = 0; i < 5; i++) do_burst(i % NREQ, 0, -1, "round_robin", 1'b0, fin);
    req = '0;
  endtask

  task automatic test_single_burst();
    int fin;
    req = 4'b0001;
    set_len(0, 3);
    do_burst(winner(req, m_ptr), 3, -1, "single", 1'b0, fin);
    req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cnt !== CW'(4) || busy !== 1'b0 || gnt !== '0 || done !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold %0d: cnt=%0d busy=%b gnt=%b done=%b, want cnt=4 busy=0 gnt=0 done=0",
                 i, cnt, busy, gnt, done);
      end
    end
  endtask

  task automatic test_wrap();
    int fin;
    req = 4'b0100;
    set_len(2, 15);
    do_burst(winner(req, m_ptr), 15, -1, "wrap", 1'b0, fin);
    req = '0;
    checks++;
    if (fin != 0 || cnt !== '0) begin
      errors++;
      $display("FAIL wrap_final: cnt=%0d, want 0", cnt);
    end
  endtask

  task automatic test_late_request();
    int fin;
    req = 4'b0001;
    set_len(0, 2);
    set_len(1, 1);
    tick();
    for (int s = 1; s <= 3; s++) begin
      if (s == 2) req = 4'b0011;
      tick();
      checks++;
      if (gnt !== 4'b0001 || cnt !== CW'(s)) begin
        errors++;
        $display("FAIL late_wait step %0d: gnt=%b cnt=%0d, want gnt=0001 cnt=%0d", s, gnt, cnt, s);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || gnt !== '0) begin
      errors++;
      $display("FAIL late_done: done=%b gnt=%b, want done=1 gnt=0", done, gnt);
    end
    m_ptr = 1;
    do_burst(1, 1, -1, "late_grant", 1'b0, fin);
    req = '0;
  endtask

  task automatic test_abort();
    int fin;
    int want;
    req = 4'b0001;
    set_len(0, 7);
    do_burst(winner(req, m_ptr), 7, 2, "abort", 1'b0, fin);
`ifdef TFF_ARB_ABORT_EN
    want = 2;
`else
    want = 8;
`endif
    checks++;
    if (cnt !== CW'(want)) begin
      errors++;
      $display("FAIL abort_final: cnt=%0d, want %0d", cnt, want);
    end
    req = '0;
  endtask

  task automatic test_random();
    int fin;
    int w;
    int l;
    for (int n = 0; n < 25; n++) begin
      req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) set_len(i, $urandom_range(0, 9));
      w = winner(req, m_ptr);
      l = int'(len[w*LEN_W +: LEN_W]);
      do_burst(w, l, -1, "random", 1'b1, fin);
      if ($urandom_range(0, 1) == 1) begin
        req = '0;
        tick();
        checks++;
        if (busy !== 1'b0 || gnt !== '0 || cnt !== CW'(fin)) begin
          errors++;
          $display("FAIL random_idle: busy=%b gnt=%b cnt=%0d, want busy=0 gnt=0 cnt=%0d",
                   busy, gnt, cnt, fin);
        end
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_burst();
    test_wrap();
    test_late_request();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
